// File: rtl/alu_dispatch_if.sv
// Request/response handshake bundle between a requester and alu_dispatch.
// The requester side is the master; the dispatch block is the slave.
interface alu_dispatch_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_in0;
    logic [31:0]      req_in1;
    logic [4:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        output req_valid, req_in0, req_in1, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_in0, req_in1, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );
endinterface

// File: rtl/alu_dispatch.sv
// Issues requests to the shared combinational ALU through one issue register and
// returns tagged results in order through a small response FIFO.
module alu_dispatch #(
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    alu_dispatch_if.slave      bus,
    output logic signed [31:0] alu_in0,
    output logic signed [31:0] alu_in1,
    output logic [4:0]         alu_op_select,
    input  logic signed [31:0] alu_out,
    output logic [15:0]        op_count
);
    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(RSP_DEPTH);
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

    function automatic logic is_illegal(input logic [4:0] op);
        return op > 5'd7;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic                     vld_p1;
    logic signed [DATA_W-1:0] in0_p1;
    logic signed [DATA_W-1:0] in1_p1;
    logic [4:0]               op_p1;
    logic [TAG_W-1:0]         tag_p1;
    logic                     err_p1;

    logic signed [DATA_W-1:0] data_mem [RSP_DEPTH];
    logic [TAG_W-1:0]         tag_mem  [RSP_DEPTH];
    logic                     err_mem  [RSP_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;

    logic full, empty, pop, advance, accept;

    assign full    = (count == CNT_W'(RSP_DEPTH));
    assign empty   = (count == '0);
    assign pop     = !empty && bus.rsp_ready;
    assign advance = vld_p1 && (!full || pop);
    assign accept  = bus.req_valid && bus.req_ready;

    // req_ready follows rsp_ready combinationally when the FIFO is full.
    assign bus.req_ready = !vld_p1 || advance;

    // ---- p0 -> p1: issue register, drives the ALU; operands hold when idle ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            in0_p1 <= '0;
            in1_p1 <= '0;
            op_p1  <= '0;
            err_p1 <= 1'b0;
        end else begin
            if (accept) begin
                vld_p1 <= 1'b1;
                in0_p1 <= bus.req_in0;
                in1_p1 <= bus.req_in1;
                op_p1  <= is_illegal(bus.req_op) ? 5'd0 : bus.req_op;
                err_p1 <= is_illegal(bus.req_op);
            end else if (advance) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tag_p1 <= bus.req_tag;
    end

    assign alu_in0       = in0_p1;
    assign alu_in1       = in1_p1;
    assign alu_op_select = op_p1;

    // ---- p1 -> p2: ALU result captured into the response FIFO ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (advance) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({advance, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            data_mem[wr_ptr] <= err_p1 ? '0 : alu_out;
            tag_mem[wr_ptr]  <= tag_p1;
            err_mem[wr_ptr]  <= err_p1;
        end
    end

    // Head fields read as zero while empty so stale entries never show.
    assign bus.rsp_valid = !empty;
    assign bus.rsp_data  = empty ? '0 : data_mem[rd_ptr];
    assign bus.rsp_tag   = empty ? '0 : tag_mem[rd_ptr];
    assign bus.rsp_err   = empty ? 1'b0 : err_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst)      op_count <= '0;
        else if (pop) op_count <= sat_inc(op_count);
    end
endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural model of the shared ALU.
module tb_alu_dispatch;
    localparam int TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] alu_in0, alu_in1, alu_out;
    logic [4:0]         alu_op_select;
    logic [15:0]        op_count;
    int                 tests = 0;
    int                 fails = 0;

    alu_dispatch_if #(.TAG_W(TAG_W)) bus ();

    alu_dispatch #(.TAG_W(TAG_W), .RSP_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .alu_in0       (alu_in0),
        .alu_in1       (alu_in1),
        .alu_op_select (alu_op_select),
        .alu_out       (alu_out),
        .op_count      (op_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_out = '0;
        case (alu_op_select)
            5'd0: alu_out = alu_in0 | alu_in1;
            5'd1: alu_out = alu_in0 & alu_in1;
            5'd2: alu_out = alu_in0 ^ alu_in1;
            5'd3: alu_out = alu_in0 + alu_in1;
            5'd4: alu_out = alu_in0 - alu_in1;
            5'd5: alu_out = alu_in0 * alu_in1;
            5'd6: alu_out = {31'd0, alu_in0 != alu_in1};
            5'd7: alu_out = {31'd0, alu_in0 == 32'd0};
            default: alu_out = '0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, want);
        end
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_in0   = a;
        bus.req_in1   = b;
        bus.req_tag   = tag;
    endtask

    logic [4:0]  s_op   [4];
    logic [31:0] s_a    [4];
    logic [31:0] s_b    [4];
    logic [31:0] s_want [4];

    initial begin
        s_op[0] = 5'd5; s_a[0] = 32'h0001_0000; s_b[0] = 32'h0001_0000; s_want[0] = 32'h0000_0000;
        s_op[1] = 5'd4; s_a[1] = 32'd0;         s_b[1] = 32'd1;         s_want[1] = 32'hFFFF_FFFF;
        s_op[2] = 5'd7; s_a[2] = 32'd0;         s_b[2] = 32'd9;         s_want[2] = 32'd1;
        s_op[3] = 5'd6; s_a[3] = 32'd4;         s_b[3] = 32'd4;         s_want[3] = 32'd0;

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_in0 = '0; bus.req_in1 = '0;
        bus.req_tag = '0; bus.rsp_ready = 1'b0;
        step(); step();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_alu_in0", alu_in0, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_op", 32'(alu_op_select), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        rst = 1'b0;

        // Single add: two edges to response
        send(5'd3, 32'd5, 32'd7, 4'd3);
        step();
        bus.req_valid = 1'b0;
        chk("add_alu_in0", alu_in0, 32'd5);
        chk("add_alu_op", 32'(alu_op_select), 32'd3);
        chk("add_not_yet", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("add_rsp_data", bus.rsp_data, 32'd12);
        chk("add_rsp_tag", 32'(bus.rsp_tag), 32'd3);
        chk("add_rsp_err", 32'(bus.rsp_err), 32'd0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("add_op_count", 32'(op_count), 32'd1);
        chk("add_drained", 32'(bus.rsp_valid), 32'd0);

        // Back-to-back stream with rsp_ready high
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) send(s_op[i], s_a[i], s_b[i], 4'(i + 1));
            else       bus.req_valid = 1'b0;
            #1;
            if (i < 4) chk("stream_req_ready", 32'(bus.req_ready), 32'd1);
            step();
            if (i >= 1) begin
                chk("stream_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("stream_rsp_data", bus.rsp_data, s_want[i-1]);
                chk("stream_rsp_tag", 32'(bus.rsp_tag), 32'(i));
            end
        end
        step();
        chk("stream_drained", 32'(bus.rsp_valid), 32'd0);
        chk("stream_op_count", 32'(op_count), 32'd5);

        // Illegal op followed by a legal xor
        send(5'd9, 32'd3, 32'd3, 4'hA);
        step();
        chk("illegal_alu_op", 32'(alu_op_select), 32'd0);
        send(5'd2, 32'h0000_00F0, 32'h0000_000F, 4'd5);
        step();
        bus.req_valid = 1'b0;
        chk("illegal_rsp_data", bus.rsp_data, 32'd0);
        chk("illegal_rsp_err", 32'(bus.rsp_err), 32'd1);
        chk("illegal_rsp_tag", 32'(bus.rsp_tag), 32'hA);
        chk("legal_alu_op", 32'(alu_op_select), 32'd2);
        step();
        chk("legal_rsp_data", bus.rsp_data, 32'h0000_00FF);
        chk("legal_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("legal_rsp_tag", 32'(bus.rsp_tag), 32'd5);
        step();
        chk("illegal_op_count", 32'(op_count), 32'd7);

        // Backpressure: three accepted, fourth stalls until the first pop
        bus.rsp_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            send(5'd3, 32'(t), 32'd100, 4'(t));
            #1;
            chk("bp_req_ready", 32'(bus.req_ready), 32'd1);
            step();
        end
        send(5'd3, 32'd3, 32'd100, 4'd3);
        #1;
        chk("bp_stall", 32'(bus.req_ready), 32'd0);
        step();
        chk("bp_still_stall", 32'(bus.req_ready), 32'd0);
        chk("bp_head_tag", 32'(bus.rsp_tag), 32'd0);
        chk("bp_head_data", bus.rsp_data, 32'd100);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_ready_on_pop", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        for (int t = 1; t < 4; t++) begin
            chk("bp_order_tag", 32'(bus.rsp_tag), 32'(t));
            chk("bp_order_data", bus.rsp_data, 32'(100 + t));
            step();
        end
        chk("bp_drained", 32'(bus.rsp_valid), 32'd0);
        chk("bp_op_count", 32'(op_count), 32'd11);

        // Reset while full with a stalled request
        bus.rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            send(5'd1, 32'hFFFF_FFFF, 32'(t + 20), 4'(t));
            step();
        end
        bus.req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mrst_op_count", 32'(op_count), 32'd0);
        chk("mrst_alu_in0", alu_in0, 32'd0);
        chk("mrst_alu_in1", alu_in1, 32'd0);
        chk("mrst_alu_op", 32'(alu_op_select), 32'd0);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mrst_no_stale", 32'(bus.rsp_valid), 32'd0);
        end
        chk("mrst_count_idle", 32'(op_count), 32'd0);

        // Counter saturation: 65536 edges give 65534 pops
        send(5'd3, 32'd1, 32'd1, 4'd0);
        for (int k = 0; k < 65536; k++) step();
        chk("sat_rsp_data", bus.rsp_data, 32'd2);
        chk("sat_pre", 32'(op_count), 32'hFFFE);
        step();
        chk("sat_reach", 32'(op_count), 32'hFFFF);
        for (int k = 0; k < 10; k++) step();
        chk("sat_hold", 32'(op_count), 32'hFFFF);
        bus.req_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
